byte_stream_ram_loader: RTL and testbench

- Synthesizable successor to the bench-only object-file loader.
- Accepts a byte stream through a valid/ready handshake and packs DATA_W/8 bytes per word, in configurable byte order.
- Writes each word to consecutive RAM addresses through the basic_ram-style cs/we/oe/mem_done interface.
- Sits between the boot/debug byte source and program RAM, and reports word count, overflow and (optionally) readback verification.

---
 rtl/byte_stream_ram_loader.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_byte_stream_ram_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_stream_ram_loader.sv
// Packs a valid/ready byte stream into DATA_W-bit words and writes them to consecutive RAM addresses.
// Latency: a word's write starts the cycle after its final byte and is held until mem_done is sampled.
// Backpressure: byte_ready is high only in COLLECT/DRAIN, so the source stalls while a write is pending.
//
// Optional feature macro: LOADER_VERIFY_EN. When defined, the words are read back after the last write,
// their sum is compared with the sum of the written words, and the verify_ok/verify_err ports exist.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start                          one-cycle pulse, begins a load when idle
//   byte_valid/data/last, byte_ready   input byte stream
//   mem_addr/wdata/rdata/done, mem_cs/we/oe   basic_ram-style RAM port
//   busy, done, word_count, overflow   load status (done is a one-cycle pulse, overflow is sticky)
//   verify_ok, verify_err          readback result, held until the next start (LOADER_VERIFY_EN only)
module byte_stream_ram_loader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int BIG_ENDIAN = 1,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              overflow
`ifdef LOADER_VERIFY_EN
  ,
  output logic              verify_ok,
  output logic              verify_err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MAXW = ADDR_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DRAIN,
`ifdef LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic [ADDR_W-1:0]  word_count_q, word_count_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_cs_q, mem_cs_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_oe_q, mem_oe_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

`ifdef LOADER_VERIFY_EN
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0]  rsum_q, rsum_d;
  logic [ADDR_W-1:0]  rd_idx_q, rd_idx_d;
  logic               verify_ok_q, verify_ok_d;
  logic               verify_err_q, verify_err_d;
  logic [DATA_W-1:0]  rsum_nxt;
  logic [ADDR_W-1:0]  rd_idx_nxt;

  assign rsum_nxt   = rsum_q + mem_rdata;
  assign rd_idx_nxt = rd_idx_q + ADDR_W'(1);
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  logic [DATA_W-1:0] buf_ins;
  logic              go_finish;

  // Pack buffer with the incoming byte dropped into the lane selected by the byte index.
  always_comb begin
    buf_ins = buf_q;
    for (int b = 0; b < NB; b++) begin
      if (idx_q == IDX_W'(b)) begin
        if (BIG_ENDIAN != 0) buf_ins[(NB-1-b)*8 +: 8] = byte_data;
        else                 buf_ins[b*8 +: 8]        = byte_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    idx_d        = idx_q;
    last_d       = last_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_oe_d     = mem_oe_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    go_finish    = 1'b0;
`ifdef LOADER_VERIFY_EN
    sum_d        = sum_q;
    rsum_d       = rsum_q;
    rd_idx_d     = rd_idx_q;
    verify_ok_d  = verify_ok_q;
    verify_err_d = verify_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_count_d = '0;
          overflow_d   = 1'b0;
          buf_d        = '0;
          idx_d        = '0;
          last_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_COLLECT;
`ifdef LOADER_VERIFY_EN
          sum_d        = '0;
          verify_ok_d  = 1'b0;
          verify_err_d = 1'b0;
`endif
        end
      end

      S_COLLECT: begin
        if (byte_valid) begin
          last_d = byte_last;
          if ((idx_q == IDX_W'(NB-1)) || byte_last) begin
            if (word_count_q == MAXW) begin
              // Capacity reached: drop this word and swallow the rest of the image.
              overflow_d = 1'b1;
              buf_d      = '0;
              idx_d      = '0;
              if (byte_last) go_finish = 1'b1;
              else           state_d   = S_DRAIN;
            end else begin
              buf_d       = buf_ins;
              mem_addr_d  = BASE + word_count_q;
              mem_wdata_d = buf_ins;
              mem_cs_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_oe_d    = 1'b0;
              state_d     = S_WRITE;
            end
          end else begin
            buf_d = buf_ins;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_WRITE: begin
        if (mem_done) begin
          mem_cs_d     = 1'b0;
          mem_we_d     = 1'b0;
          word_count_d = word_count_q + ADDR_W'(1);
          buf_d        = '0;
          idx_d        = '0;
`ifdef LOADER_VERIFY_EN
          sum_d        = sum_q + mem_wdata_q;
`endif
          if (last_q) begin
`ifdef LOADER_VERIFY_EN
            // Reads start straight away, from the first address of the image.
            rd_idx_d   = '0;
            rsum_d     = '0;
            mem_addr_d = BASE;
            mem_cs_d   = 1'b1;
            mem_oe_d   = 1'b1;
            state_d    = S_VERIFY;
`else
            go_finish  = 1'b1;
`endif
          end else begin
            state_d = S_COLLECT;
          end
        end
      end

`ifdef LOADER_VERIFY_EN
      S_VERIFY: begin
        if (mem_done) begin
          rsum_d   = rsum_nxt;
          rd_idx_d = rd_idx_nxt;
          if (rd_idx_nxt == word_count_q) begin
            mem_cs_d     = 1'b0;
            mem_oe_d     = 1'b0;
            verify_ok_d  = (rsum_nxt == sum_q);
            verify_err_d = (rsum_nxt != sum_q);
            go_finish    = 1'b1;
          end else begin
            mem_addr_d = BASE + rd_idx_nxt;
          end
        end
      end
`endif

      S_DRAIN: begin
        if (byte_valid && byte_last) go_finish = 1'b1;
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (go_finish) begin
      state_d = S_FINISH;
      done_d  = 1'b1;
      busy_d  = 1'b0;
`ifdef LOADER_VERIFY_EN
      // An overflowed image is never read back and always reports an error.
      if (overflow_d) begin
        verify_ok_d  = 1'b0;
        verify_err_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef LOADER_VERIFY_EN
      sum_q        <= '0;
      rsum_q       <= '0;
      rd_idx_q     <= '0;
      verify_ok_q  <= 1'b0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_oe_q     <= mem_oe_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef LOADER_VERIFY_EN
      sum_q        <= sum_d;
      rsum_q       <= rsum_d;
      rd_idx_q     <= rd_idx_d;
      verify_ok_q  <= verify_ok_d;
      verify_err_q <= verify_err_d;
`endif
    end
  end

  assign byte_ready = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_oe     = mem_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;
  assign overflow   = overflow_q;
`ifdef LOADER_VERIFY_EN
  assign verify_ok  = verify_ok_q;
  assign verify_err = verify_err_q;
`endif

endmodule

// File: tb/tb_byte_stream_ram_loader.sv
// Bench for byte_stream_ram_loader: two instances (big-endian at base 0x100, little-endian with a
// two-word limit), each with a RAM model of programmable mem_done latency. Expected writes are queued
// when a load is set up and popped as the RAM model completes each write.
module tb_byte_stream_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start[2], byte_valid[2], byte_last[2], byte_ready[2];
  logic [7:0]  byte_data[2];
  logic [15:0] mem_addr[2], word_count[2];
  logic [31:0] mem_wdata[2], mem_rdata[2];
  logic        mem_done[2], mem_cs[2], mem_we[2], mem_oe[2];
  logic        busy[2], done[2], overflow[2];
`ifdef LOADER_VERIFY_EN
  logic        verify_ok[2], verify_err[2];
`endif

  typedef struct {
    int          dut;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          lat[2];
  int          cnt[2];
  logic [15:0] hold_addr[2];
  logic [31:0] hold_wdata[2];
  logic [31:0] ram[2][512];
  logic [7:0]  stim[64];
  bit          corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = '0;

  always #5 clk = ~clk;

  byte_stream_ram_loader #(.DATA_W(32), .ADDR_W(16), .BIG_ENDIAN(1), .BASE_ADDR(32'h100), .MAX_WORDS(8)) u_be (
`ifdef LOADER_VERIFY_EN
    .verify_ok(verify_ok[0]), .verify_err(verify_err[0]),
`endif
    .clk(clk), .rst(rst), .start(start[0]),
    .byte_valid(byte_valid[0]), .byte_data(byte_data[0]), .byte_last(byte_last[0]), .byte_ready(byte_ready[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_done(mem_done[0]),
    .mem_cs(mem_cs[0]), .mem_we(mem_we[0]), .mem_oe(mem_oe[0]),
    .busy(busy[0]), .done(done[0]), .word_count(word_count[0]), .overflow(overflow[0])
  );

  byte_stream_ram_loader #(.DATA_W(32), .ADDR_W(16), .BIG_ENDIAN(0), .BASE_ADDR(0), .MAX_WORDS(2)) u_le (
`ifdef LOADER_VERIFY_EN
    .verify_ok(verify_ok[1]), .verify_err(verify_err[1]),
`endif
    .clk(clk), .rst(rst), .start(start[1]),
    .byte_valid(byte_valid[1]), .byte_data(byte_data[1]), .byte_last(byte_last[1]), .byte_ready(byte_ready[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_done(mem_done[1]),
    .mem_cs(mem_cs[1]), .mem_we(mem_we[1]), .mem_oe(mem_oe[1]),
    .busy(busy[1]), .done(done[1]), .word_count(word_count[1]), .overflow(overflow[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAM model: mem_done rises lat cycles after cs is seen, and drops for one cycle after each access.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst || !mem_cs[d]) begin
        cnt[d]      <= 0;
        mem_done[d] <= 1'b0;
      end else if (mem_done[d]) begin
        cnt[d]      <= 0;
        mem_done[d] <= 1'b0;
      end else begin
        if (cnt[d] == 0) begin
          hold_addr[d]  <= mem_addr[d];
          hold_wdata[d] <= mem_wdata[d];
        end else if (mem_we[d]) begin
          check("wr_addr_stable", mem_addr[d], hold_addr[d]);
          check("wr_data_stable", mem_wdata[d], hold_wdata[d]);
        end
        if (cnt[d] >= lat[d] - 1) begin
          mem_done[d] <= 1'b1;
          if (mem_we[d]) begin
            ram[d][mem_addr[d][8:0]] <= mem_wdata[d];
            check("wr_oe_low", mem_oe[d], 1'b0);
            if (exp_q.size() == 0) begin
              check("wr_unexpected", 1'b1, 1'b0);
            end else begin
              check("wr_dut", d, exp_q[0].dut);
              check("wr_addr", mem_addr[d], exp_q[0].addr);
              check("wr_data", mem_wdata[d], exp_q[0].data);
              void'(exp_q.pop_front());
            end
          end else begin
            mem_rdata[d] <= ram[d][mem_addr[d][8:0]] ^
                            ((corrupt_en && mem_addr[d] == corrupt_addr) ? 32'h0000_0100 : 32'h0);
          end
        end else begin
          cnt[d] <= cnt[d] + 1;
        end
      end
    end
  end

  task automatic push_exp(input int d, input logic [15:0] addr, input logic [31:0] data);
    wr_t e;
    e.dut = d; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // Reference packing of stim[0..n-1] into 4-byte words, zero-padded, capped at maxw words.
  task automatic push_model(input int d, input int n, input bit be, input logic [15:0] base, input int maxw);
    logic [31:0] w;
    for (int k = 0; k * 4 < n && k < maxw; k++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        if (k * 4 + b < n) begin
          if (be) w[(3-b)*8 +: 8] = stim[k*4+b];
          else    w[b*8 +: 8]     = stim[k*4+b];
        end
      end
      push_exp(d, base + 16'(k), w);
    end
  endtask

  task automatic start_load(input int d);
    @(posedge clk); #1 start[d] = 1'b1;
    @(posedge clk); #1 start[d] = 1'b0;
  endtask

  // Offers stim[0..n-1]; in random mode byte_valid drops at random and a stray start is pulsed mid-image.
  task automatic send_bytes(input int d, input int n, input bit rnd);
    int  i;
    int  guard;
    bit  rdy;
    i = 0; guard = 0;
    while (i < n && guard < 2000) begin
      start[d] = rnd && (i == 3);
      if (rnd && $urandom_range(0, 2) == 0) begin
        byte_valid[d] = 1'b0;
      end else begin
        byte_valid[d] = 1'b1;
        byte_data[d]  = stim[i];
        byte_last[d]  = (i == n - 1);
      end
      rdy = byte_ready[d];
      @(posedge clk); #1;
      if (byte_valid[d] && rdy) i++;
      guard++;
    end
    start[d] = 1'b0; byte_valid[d] = 1'b0; byte_last[d] = 1'b0;
    check("stream_accepted", i, n);
  endtask

  task automatic wait_done(input int d, input int exp_wc, input bit exp_ovf);
    int guard;
    int extra;
    guard = 0;
    while (!done[d] && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done_seen", done[d], 1'b1);
    check("busy_at_done", busy[d], 1'b0);
    check("word_count", word_count[d], exp_wc);
    check("overflow", overflow[d], exp_ovf);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done[d]) extra++;
    end
    check("done_once", extra, 0);
    check("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; byte_valid[d] = 1'b0; byte_last[d] = 1'b0; byte_data[d] = '0;
      lat[d] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", busy[d], 1'b0);
      check("rst_done", done[d], 1'b0);
      check("rst_wc", word_count[d], 16'h0);
      check("rst_ovf", overflow[d], 1'b0);
      check("rst_cs", mem_cs[d], 1'b0);
      check("rst_we", mem_we[d], 1'b0);
      check("rst_oe", mem_oe[d], 1'b0);
      check("rst_ready", byte_ready[d], 1'b0);
      check("rst_addr", mem_addr[d], 16'h0);
      check("rst_wdata", mem_wdata[d], 32'h0);
    end
    rst = 1'b0;

    // Big-endian two-word image.
    stim[0] = 8'hDE; stim[1] = 8'hAD; stim[2] = 8'hBE; stim[3] = 8'hEF;
    stim[4] = 8'h01; stim[5] = 8'h02; stim[6] = 8'h03; stim[7] = 8'h04;
    push_exp(0, 16'h100, 32'hDEADBEEF);
    push_exp(0, 16'h101, 32'h01020304);
    start_load(0); send_bytes(0, 8, 1'b0); wait_done(0, 2, 1'b0);

    // Same stream, little-endian.
    push_exp(1, 16'h000, 32'hEFBEADDE);
    push_exp(1, 16'h001, 32'h04030201);
    start_load(1); send_bytes(1, 8, 1'b0); wait_done(1, 2, 1'b0);

    // Short image, zero-padded into one word at the base address.
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
    push_exp(0, 16'h100, 32'hAABBCC00);
    start_load(0); send_bytes(0, 3, 1'b0); wait_done(0, 1, 1'b0);

    // Overflow: 16 bytes into a two-word limit; third word dropped, rest drained.
    for (int k = 0; k < 16; k++) stim[k] = 8'h10 + 8'(k);
    push_exp(1, 16'h000, 32'h13121110);
    push_exp(1, 16'h001, 32'h17161514);
    start_load(1); send_bytes(1, 16, 1'b0); wait_done(1, 2, 1'b1);
`ifdef LOADER_VERIFY_EN
    check("ovf_verify_err", verify_err[1], 1'b1);
    check("ovf_verify_ok", verify_ok[1], 1'b0);
`endif

    // Slow RAM with a ragged byte stream.
    lat[0] = 3; lat[1] = 3;
    for (int k = 0; k < 20; k++) stim[k] = 8'($urandom_range(0, 255));
    push_model(0, 20, 1'b1, 16'h100, 8);
    start_load(0); send_bytes(0, 20, 1'b1); wait_done(0, 5, 1'b0);
    push_model(1, 6, 1'b0, 16'h000, 2);
    start_load(1); send_bytes(1, 6, 1'b1); wait_done(1, 2, 1'b0);

    // Reset while a write is waiting on mem_done.
    lat[0] = 20;
    for (int k = 0; k < 4; k++) stim[k] = 8'h50 + 8'(k);
    start_load(0); send_bytes(0, 4, 1'b0);
    guard = 0;
    while (!mem_cs[0] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("pre_rst_cs", mem_cs[0], 1'b1);
    check("pre_rst_busy", busy[0], 1'b1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_rst_cs", mem_cs[0], 1'b0);
    check("async_rst_we", mem_we[0], 1'b0);
    check("async_rst_busy", busy[0], 1'b0);
    check("async_rst_wc", word_count[0], 16'h0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();

    // Recovery after reset.
    lat[0] = 1;
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
    push_exp(0, 16'h100, 32'hAABBCC00);
    start_load(0); send_bytes(0, 3, 1'b0); wait_done(0, 1, 1'b0);

`ifdef LOADER_VERIFY_EN
    lat[0] = 2;
    for (int k = 0; k < 16; k++) stim[k] = 8'($urandom_range(0, 255));
    push_model(0, 16, 1'b1, 16'h100, 8);
    start_load(0); send_bytes(0, 16, 1'b0); wait_done(0, 4, 1'b0);
    check("verify_ok", verify_ok[0], 1'b1);
    check("verify_err", verify_err[0], 1'b0);
    corrupt_en = 1'b1; corrupt_addr = 16'h102;
    push_model(0, 16, 1'b1, 16'h100, 8);
    start_load(0); send_bytes(0, 16, 1'b0); wait_done(0, 4, 1'b0);
    check("corrupt_verify_ok", verify_ok[0], 1'b0);
    check("corrupt_verify_err", verify_err[0], 1'b1);
    corrupt_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, got t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
